// File: rtl/avalon_mm_mult_array_slave.sv
// Avalon-MM slave with NCH independent unsigned SZ x SZ shift-add multipliers.
// Each channel exposes A, B, CTRL/status, RES_LO and RES_HI word registers.
module avalon_mm_mult_array_slave #(
    parameter int unsigned SZ  = 32,
    parameter int unsigned NCH = 2,
    parameter int unsigned AW  = $clog2(NCH * 8)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] address,
    input  logic          read,
    input  logic          write,
    input  logic [SZ-1:0] writedata,
    output logic [SZ-1:0] readdata,
    output logic          readdatavalid,
    output logic          waitrequest,
    output logic          irq
);

    localparam int unsigned CW = (AW > 3) ? AW - 3 : 1;
    localparam int unsigned NW = $clog2(SZ);

    typedef enum logic {StIdle, StRun} state_e;

    state_e          state_q  [NCH];
    logic [SZ-1:0]   a_q      [NCH];
    logic [SZ-1:0]   b_q      [NCH];
    logic [SZ-1:0]   mplier_q [NCH];
    logic [2*SZ-1:0] mcand_q  [NCH];
    logic [2*SZ-1:0] acc_q    [NCH];
    logic [2*SZ-1:0] res_q    [NCH];
    logic [NW-1:0]   cnt_q    [NCH];
    logic [NCH-1:0]  done_q;
    logic [NCH-1:0]  irq_en_q;

    logic [SZ-1:0]   readdata_q;
    logic            readdatavalid_q;
    logic            irq_q;

    logic [2:0]      reg_sel;
    logic [CW-1:0]   ch_sel;
    logic            ch_ok;
    logic [NCH-1:0]  ch_hit;
    logic            sel_busy;
    logic            sel_done;
    logic            sel_irq_en;
    logic [SZ-1:0]   sel_a;
    logic [SZ-1:0]   sel_b;
    logic [2*SZ-1:0] sel_res;
    logic [SZ-1:0]   rdata_d;
    logic            wr_acc;
    logic            rd_acc;

    assign reg_sel = address[2:0];
    assign ch_sel  = CW'(address >> 3);
    assign ch_ok   = ({1'b0, ch_sel} < (CW + 1)'(NCH));

    always_comb begin
        ch_hit     = '0;
        sel_busy   = 1'b0;
        sel_done   = 1'b0;
        sel_irq_en = 1'b0;
        sel_a      = '0;
        sel_b      = '0;
        sel_res    = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_ok && ch_sel == CW'(i)) begin
                ch_hit[i]  = 1'b1;
                sel_busy   = (state_q[i] == StRun);
                sel_done   = done_q[i];
                sel_irq_en = irq_en_q[i];
                sel_a      = a_q[i];
                sel_b      = b_q[i];
                sel_res    = res_q[i];
            end
        end
    end

    // Only operand writes and START on a running channel stall; reads never do.
    assign waitrequest = !rst && write && ch_ok && sel_busy &&
                         (reg_sel == 3'd0 || reg_sel == 3'd1 ||
                          (reg_sel == 3'd2 && writedata[0]));

    assign wr_acc = write && !waitrequest;
    assign rd_acc = read && !write;

    always_comb begin
        rdata_d = '0;
        if (ch_ok) begin
            case (reg_sel)
                3'd0:    rdata_d = sel_a;
                3'd1:    rdata_d = sel_b;
                3'd2:    rdata_d[2:0] = {sel_irq_en, sel_done, sel_busy};
                3'd3:    rdata_d = sel_res[SZ-1:0];
                3'd4:    rdata_d = sel_res[2*SZ-1:SZ];
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i]  <= StIdle;
                a_q[i]      <= '0;
                b_q[i]      <= '0;
                mplier_q[i] <= '0;
                mcand_q[i]  <= '0;
                acc_q[i]    <= '0;
                res_q[i]    <= '0;
                cnt_q[i]    <= '0;
            end
            done_q          <= '0;
            irq_en_q        <= '0;
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
            irq_q           <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wr_acc && ch_hit[i] && reg_sel == 3'd0) a_q[i] <= writedata;
                if (wr_acc && ch_hit[i] && reg_sel == 3'd1) b_q[i] <= writedata;
                if (wr_acc && ch_hit[i] && reg_sel == 3'd2) irq_en_q[i] <= writedata[1];
                // Placed before the FSM so a same-edge completion overrides the clear.
                if (rd_acc && ch_hit[i] && reg_sel == 3'd4) done_q[i] <= 1'b0;

                unique case (state_q[i])
                    StIdle: begin
                        if (wr_acc && ch_hit[i] && reg_sel == 3'd2 && writedata[0]) begin
                            state_q[i]  <= StRun;
                            mcand_q[i]  <= {{SZ{1'b0}}, a_q[i]};
                            mplier_q[i] <= b_q[i];
                            acc_q[i]    <= '0;
                            cnt_q[i]    <= '0;
                            done_q[i]   <= 1'b0;
                        end
                    end
                    StRun: begin
                        if (mplier_q[i][0]) acc_q[i] <= acc_q[i] + mcand_q[i];
                        mcand_q[i]  <= mcand_q[i] << 1;
                        mplier_q[i] <= mplier_q[i] >> 1;
                        cnt_q[i]    <= cnt_q[i] + 1'b1;
                        if (cnt_q[i] == NW'(SZ - 1)) begin
                            res_q[i]   <= acc_q[i] + (mplier_q[i][0] ? mcand_q[i] : '0);
                            state_q[i] <= StIdle;
                            done_q[i]  <= 1'b1;
                        end
                    end
                    default: state_q[i] <= StIdle;
                endcase
            end
            readdatavalid_q <= rd_acc;
            if (rd_acc) readdata_q <= rdata_d;
            irq_q <= |(done_q & irq_en_q);
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = readdatavalid_q;
    assign irq           = irq_q;

endmodule

// File: doc/avalon_mm_mult_array_slave.md
Name: avalon_mm_mult_array_slave

Overview:
Avalon-MM slave exposing NCH independent unsigned SZ x SZ multiplier channels through a memory-mapped register file. Each channel has a sequential shift-add multiplier of fixed SZ-cycle latency, plus per-channel status, done latching and interrupt enable. It supersedes the single-channel fixed-port multiplier wrapper: the host bus writes operands, starts the multiply, polls or takes an interrupt, then reads the 2*SZ result.

Parameters:
SZ, 32, operand width and Avalon data width (bits); legal range 8..64.
NCH, 2, number of multiplier channels; legal range 1..16.
AW, $clog2(NCH*8), word address width (8 word slots per channel, derived).

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous reset, active-high.
address  in  AW  word address; channel = address[AW-1:3], register = address[2:0].
read  in  1  read request.
write  in  1  write request; read and write both high = write wins, read dropped.
writedata  in  SZ  write data.
readdata  out  SZ  read data; valid only with readdatavalid.
readdatavalid  out  1  one-cycle pulse, exactly 1 cycle after an accepted read.
waitrequest  out  1  stall; request held by host while high.
irq  out  1  OR over channels of (done & irq_en).

Behaviour:
- Reset (rst high at an edge): all A/B/result registers are 0, busy/done/irq_en are 0, readdata is 0, readdatavalid is 0, irq is 0. An in-flight multiply is abandoned. waitrequest is combinational and is 0 during reset.
- Register map per channel (word offsets):
  - 0 = A (RW)
  - 1 = B (RW)
  - 2 = CTRL. Write: bit0 START, bit1 IRQ_EN. Read: bit0 busy, bit1 done, bit2 irq_en, others 0.
  - 3 = RES_LO (RO, result[SZ-1:0])
  - 4 = RES_HI (RO, result[2SZ-1:SZ])
  - 5..7 reserved: read 0, write ignored.
  - Channel index >= NCH: read 0, write ignored, no stall.
- Accept rule: a request is accepted on an edge where (read|write) and waitrequest is low.
- waitrequest is high only when write is high, the addressed channel is busy, and the register is A, B or CTRL with writedata[0]=1. Reads never stall.
- Read latency: fixed at 1 cycle. Back-to-back reads are accepted every cycle.
- Channel state machine: IDLE -> RUN -> IDLE.
  - START accepted in IDLE at edge T: operands are snapshotted, the result accumulator clears, done clears, irq_en is updated from bit1, and busy is 1 from T+1.
  - RUN: one shift-add step per cycle, SZ steps in total.
  - At edge T+SZ: the full 2*SZ result is written to RES, busy falls, and done sets, all visible at T+SZ+1.
  - Writing CTRL with bit0=0 only updates irq_en. It never aborts a run.
- Operand snapshot: writes to A/B during RUN are stalled and never corrupt the run.
- done clears on an accepted read of RES_HI, or on a new START. If a RES_HI read and the done-set happen on the same edge, done-set wins (the read returns the old RES_HI).
- Arithmetic: unsigned, exact. The maximum product (2^SZ-1)^2 fits in 2*SZ bits with no overflow.
- irq is registered: it asserts the cycle after done&irq_en becomes true, and drops the cycle after either bit clears.
- Channels are fully independent and may run concurrently. Accesses to an idle channel are never stalled by a busy one.
- Reset mid-run: busy=0 and done=0 on the following cycle, RES=0, and no irq.

Test Plan:
- Reset, then read every register of ch0 and ch1 -> all read 0; readdatavalid is exactly 1 cycle after each read; irq=0.
- SZ=8: write A=0xFF, B=0xFF, CTRL=0x1 at T -> busy=1 T+1..T+8, done=1 at T+9, RES_LO=0x01, RES_HI=0xFE; reading RES_HI clears done.
- Write B=0x03 while ch0 busy -> waitrequest held high until busy falls; the write then lands; the running result is unaffected (0x05*0x07=0x0023).
- CTRL=0x3 with A=0, B=0x55 on ch1 -> RES=0, done=1, irq=1 one cycle later; read RES_HI -> irq=0 next cycle.
- Start ch0 and ch1 on consecutive cycles with distinct operands -> both results are correct, done flags set 1 cycle apart, and an idle ch1 A write during ch0 RUN sees no stall.
- Assert rst at T+4 of a run -> busy=0 and done=0 afterwards, RES reads 0, irq never asserts; a fresh START then completes normally.
